// File: rtl/golomb_stream_decoder_pkg.sv
// golomb_pkg: shared defaults, FSM state type and codeword-length helper for
// the Golomb-Rice stream decoder.
package golomb_pkg;

  localparam int unsigned IN_W_D  = 16;
  localparam int unsigned BUF_W_D = 64;
  localparam int unsigned QMAX_D  = 23;
  localparam int unsigned K_W_D   = 4;
  localparam int unsigned ESC_W_D = 16;
  localparam int unsigned OUT_W_D = 16;

  typedef enum logic {RUN, DRAIN} state_t;

  // Bits consumed by one codeword: unary prefix + terminator + k remainder
  // bits, or the saturated prefix followed by the raw escape payload.
  function automatic int unsigned cw_len(input int unsigned q,
                                         input int unsigned k,
                                         input logic        esc,
                                         input int unsigned qmax  = QMAX_D,
                                         input int unsigned esc_w = ESC_W_D);
    return esc ? qmax + esc_w : q + 1 + k;
  endfunction

endpackage

// File: rtl/golomb_stream_decoder_if.sv
// Stream-side and symbol-side handshake bundle of the decoder.
//   in_data/in_valid/in_last/in_ready      : packed MSB-first word stream
//   out_value/out_escape/out_last/out_valid/out_ready : decoded symbols
// master = producer/consumer around the decoder, slave = the decoder.
interface golomb_stream_decoder_if #(
  parameter int unsigned IN_W  = golomb_pkg::IN_W_D,
  parameter int unsigned OUT_W = golomb_pkg::OUT_W_D
) ();
  logic [IN_W-1:0]  in_data;
  logic             in_valid;
  logic             in_last;
  logic             in_ready;
  logic [OUT_W-1:0] out_value;
  logic             out_escape;
  logic             out_last;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_value, out_escape, out_last, out_valid
  );

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_value, out_escape, out_last, out_valid
  );
endinterface

// File: rtl/golomb_stream_decoder_prefix.sv
// golomb_prefix_count: leading-zero priority encoder over a QMAX-bit window.
//   win : window, win[QMAX-1] is the first stream bit
//   q   : number of 0s before the first 1 (QMAX when none)
//   esc : window is all zeros (prefix saturated)
module golomb_prefix_count
  import golomb_pkg::*;
#(
  parameter  int unsigned QMAX = QMAX_D,
  localparam int unsigned QW   = $clog2(QMAX + 1)
) (
  input  logic [QMAX-1:0] win,
  output logic [QW-1:0]   q,
  output logic            esc
);

  always_comb begin
    q   = QW'(QMAX);
    esc = 1'b1;
    for (int unsigned i = 0; i < QMAX; i++) begin
      if (esc && win[QMAX-1-i]) begin
        q   = QW'(i);
        esc = 1'b0;
      end
    end
  end

endmodule

// File: rtl/golomb_stream_decoder.sv
// golomb_stream_decoder: Golomb-Rice symbol decoder with escape mode.
//   clk, rst_n : clock, asynchronous active-low reset
//   k          : Rice parameter, stable while a stream is in flight
//   bus        : slave side of golomb_stream_decoder_if (word stream in,
//                symbol stream out, valid/ready on both)
// Valid bits sit at the top of buf_q; everything below fill is kept zero so
// prefix counting past the end of the data always reads zeros.
module golomb_stream_decoder
  import golomb_pkg::*;
#(
  parameter int unsigned IN_W  = IN_W_D,
  parameter int unsigned BUF_W = BUF_W_D,
  parameter int unsigned QMAX  = QMAX_D,
  parameter int unsigned K_W   = K_W_D,
  parameter int unsigned ESC_W = ESC_W_D,
  parameter int unsigned OUT_W = OUT_W_D
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [K_W-1:0]          k,
  golomb_stream_decoder_if.slave  bus
);

  localparam int unsigned FW = $clog2(BUF_W + 1);
  localparam int unsigned QW = $clog2(QMAX + 1);
  localparam int unsigned RW = 2 ** K_W;
  localparam logic [FW-1:0] MIN_FILL = FW'(QMAX + ESC_W);
  localparam logic [FW-1:0] ROOM     = FW'(BUF_W - IN_W);

  state_t            state, state_nx;
  logic [BUF_W-1:0]  buf_q, shifted, nbuf;
  logic [FW-1:0]     fill, len, rem, nfill, nlen;
  logic [QW-1:0]     q, nq;
  logic              esc, nesc;
  logic              acc, dec, fits, ended, is_last, drop;
  logic [RW-1:0]     rwin;
  logic [K_W:0]      rsh;
  logic [OUT_W-1:0]  val;

  golomb_prefix_count #(.QMAX(QMAX)) u_pfx (
    .win (buf_q[BUF_W-1 -: QMAX]),
    .q   (q),
    .esc (esc)
  );

  // Prefix of the buffer as it will look after this cycle's decode/append;
  // tells whether the symbol decoded now is the final one of the stream.
  golomb_prefix_count #(.QMAX(QMAX)) u_npfx (
    .win (nbuf[BUF_W-1 -: QMAX]),
    .q   (nq),
    .esc (nesc)
  );

  assign bus.in_ready = (state == RUN) && (fill <= ROOM);

  always_comb begin
    len  = FW'(cw_len(32'(q), 32'(k), esc, QMAX, ESC_W));
    nlen = FW'(cw_len(32'(nq), 32'(k), nesc, QMAX, ESC_W));
    fits = (len <= fill);
    acc  = bus.in_valid && bus.in_ready;
    dec  = (!bus.out_valid || bus.out_ready) &&
           ((state == RUN) ? (fill >= MIN_FILL) : fits);
    rem     = dec ? fill - len : fill;
    shifted = dec ? buf_q << len : buf_q;
    nbuf    = shifted;
    nfill   = rem;
    if (acc) begin
      nbuf  = shifted | ({{(BUF_W-IN_W){1'b0}}, bus.in_data} << (ROOM - rem));
      nfill = rem + FW'(IN_W);
    end
    // Remainder field starts right after the terminator bit.
    rwin = buf_q[(BUF_W - 2) - int'(q) -: RW];
    rsh  = (K_W+1)'(RW) - (K_W+1)'(k);
    if (esc) val = OUT_W'(buf_q[BUF_W-1-QMAX -: ESC_W]);
    else     val = (OUT_W'(q) << k) | OUT_W'(rwin >> rsh);
  end

  // The end of a stream is only known once its last word is accepted, so a
  // symbol is flagged last when it is decoded in or after that cycle and
  // leaves no complete codeword behind; the leftover bits go with it.
  always_comb begin
    state_nx = state;
    ended    = (state == DRAIN) || (acc && bus.in_last);
    is_last  = dec && ended && (nlen > nfill);
    drop     = (state == DRAIN) && !fits;
    if (is_last || drop)          state_nx = RUN;
    else if (acc && bus.in_last)  state_nx = DRAIN;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q          <= '0;
      fill           <= '0;
      bus.out_value  <= '0;
      bus.out_escape <= 1'b0;
      bus.out_last   <= 1'b0;
      bus.out_valid  <= 1'b0;
    end else begin
      if (is_last || drop) begin
        buf_q <= '0;
        fill  <= '0;
      end else begin
        buf_q <= nbuf;
        fill  <= nfill;
      end
      if (dec) begin
        bus.out_value  <= val;
        bus.out_escape <= esc;
        bus.out_last   <= is_last;
        bus.out_valid  <= 1'b1;
      end else if (bus.out_ready) begin
        bus.out_valid  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_golomb_stream_decoder.sv
module tb_golomb_stream_decoder;

  localparam int unsigned QMAX  = 23;
  localparam int unsigned ESC_W = 16;

  typedef struct {
    logic [15:0] v;
    logic        e;
    logic        l;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] k = '0;

  golomb_stream_decoder_if #(.IN_W(16), .OUT_W(16)) bus ();

  golomb_stream_decoder #(
    .IN_W(16), .BUF_W(64), .QMAX(23), .K_W(4), .ESC_W(16), .OUT_W(16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .k     (k),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          rdy_mode = 0;   // 0: always ready, 1: random, 2: held low
  bit          in_stall_en = 1'b0;
  logic [15:0] wq[$];
  bit          saw_block;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [15:0] v, input logic e, input logic l);
    exp_t x;
    x.v = v; x.e = e; x.l = l;
    sb.push_back(x);
  endtask

  // Reference: walk the stream as a flat bit list and apply the code rules.
  function automatic void model(input logic [15:0] w[$], input int unsigned kk);
    bit          bits[$];
    exp_t        tmp[$];
    exp_t        x;
    int unsigned pos, z, n, r, v;
    bit          done;
    foreach (w[i]) for (int b = 15; b >= 0; b--) bits.push_back(w[i][b]);
    n = bits.size();
    pos = 0;
    done = 0;
    while (!done) begin
      z = 0;
      while (z < QMAX && pos + z < n && bits[pos + z] == 1'b0) z++;
      if (z == QMAX) begin
        if (pos + QMAX + ESC_W > n) done = 1;
        else begin
          v = 0;
          for (int unsigned i = 0; i < ESC_W; i++) v = v * 2 + bits[pos + QMAX + i];
          x.v = 16'(v); x.e = 1'b1; x.l = 1'b0;
          tmp.push_back(x);
          pos += QMAX + ESC_W;
        end
      end else if (pos + z + 1 + kk > n) begin
        done = 1;
      end else begin
        r = 0;
        for (int unsigned i = 0; i < kk; i++) r = r * 2 + bits[pos + z + 1 + i];
        v = (z * (1 << kk) + r) % 65536;
        x.v = 16'(v); x.e = 1'b0; x.l = 1'b0;
        tmp.push_back(x);
        pos += z + 1 + kk;
      end
    end
    if (tmp.size() > 0) tmp[tmp.size() - 1].l = 1'b1;
    foreach (tmp[i]) sb.push_back(tmp[i]);
  endfunction

  // Called at posedge+#1; returns at posedge+#1 after the accepting edge.
  task automatic send_word(input logic [15:0] w, input logic last);
    int n;
    bit ok;
    if (in_stall_en) begin
      repeat ($urandom_range(0, 2)) begin
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    bus.in_data = w;
    bus.in_last = last;
    bus.in_valid = 1'b1;
    ok = 0;
    n = 0;
    while (!ok && n < 500) begin
      @(negedge clk);
      ok = bus.in_ready;
      n++;
    end
    chk("word_accept", 32'(ok), 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
  endtask

  task automatic send_stream(input logic [15:0] w[$]);
    foreach (w[i]) send_word(w[i], (i == w.size() - 1));
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    chk({name, "_all_symbols"}, 32'(sb.size()), 0);
    chk({name, "_in_ready_back"}, 32'(bus.in_ready), 1);
    sb.delete();
    @(posedge clk); #1;
  endtask

  // Consumer handshake driver.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = ($urandom_range(0, 3) != 0);
        default: bus.out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: pops the scoreboard on every symbol handshake, and checks that
  // a stalled symbol does not change.
  logic        hold = 1'b0;
  logic [15:0] hv;
  logic        he, hl;
  exp_t        ex;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold = 1'b0;
      end else begin
        if (hold) begin
          chk("hold_valid", 32'(bus.out_valid), 1);
          chk("hold_value", 32'(bus.out_value), 32'(hv));
          chk("hold_flags", {30'd0, bus.out_escape, bus.out_last}, {30'd0, he, hl});
        end
        if (bus.out_valid && bus.out_ready) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_symbol actual=0x%0h required=none", bus.out_value);
          end else begin
            ex = sb.pop_front();
            chk("value", 32'(bus.out_value), 32'(ex.v));
            chk("escape", 32'(bus.out_escape), 32'(ex.e));
            chk("last", 32'(bus.out_last), 32'(ex.l));
          end
        end
        hold = bus.out_valid && !bus.out_ready;
        hv = bus.out_value;
        he = bus.out_escape;
        hl = bus.out_last;
      end
    end
  end

  initial begin
    int n, nw, sel;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.in_last = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_out_value", 32'(bus.out_value), 0);
    chk("rst_out_escape", 32'(bus.out_escape), 0);
    chk("rst_out_last", 32'(bus.out_last), 0);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic Rice decode, k=2, with pad bits at the end.
    k = 4'd2;
    push_exp(16'd1, 1'b0, 1'b0);
    push_exp(16'd6, 1'b0, 1'b0);
    push_exp(16'd11, 1'b0, 1'b1);
    send_word(16'hAC70, 1'b1);
    chk("latency_edge1", 32'(bus.out_valid), 0);
    @(posedge clk); #1;
    chk("latency_edge2", 32'(bus.out_valid), 1);
    wait_done("basic");

    // Escape symbol followed by a one-bit codeword, k=0.
    k = 4'd0;
    push_exp(16'hBEEF, 1'b1, 1'b0);
    push_exp(16'h0000, 1'b0, 1'b1);
    send_word(16'h0000, 1'b0);
    send_word(16'h017D, 1'b0);
    send_word(16'hDF00, 1'b1);
    wait_done("escape");

    // Value wrap: k=15, q=3, r=0x7FFF.
    k = 4'd15;
    push_exp(16'hFFFF, 1'b0, 1'b1);
    send_word(16'h1FFF, 1'b0);
    send_word(16'hE000, 1'b1);
    wait_done("wrap");

    // Backpressure: consumer stalls for 10 cycles once symbols start.
    k = 4'd3;
    wq.delete();
    for (int i = 0; i < 10; i++) wq.push_back(16'($urandom));
    wq[9] = wq[9] | 16'h8000;
    model(wq, 3);
    saw_block = 1'b0;
    fork
      send_stream(wq);
      begin
        n = 0;
        while (!bus.out_valid && n < 200) begin
          @(negedge clk);
          n++;
        end
        rdy_mode = 2;
        repeat (10) begin
          @(negedge clk);
          if (!bus.in_ready) saw_block = 1'b1;
        end
        rdy_mode = 0;
      end
    join
    chk("bp_in_ready_drop", 32'(saw_block), 1);
    wait_done("backpressure");

    // Reset while draining with a symbol held on the output.
    k = 4'd2;
    rdy_mode = 2;
    repeat (2) @(posedge clk);
    #1;
    send_word(16'hAC70, 1'b1);
    n = 0;
    while (!bus.out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("rst_pre_valid", 32'(bus.out_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", 32'(bus.out_valid), 0);
    chk("rst_mid_value", 32'(bus.out_value), 0);
    chk("rst_mid_last", 32'(bus.out_last), 0);
    chk("rst_mid_escape", 32'(bus.out_escape), 0);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    rdy_mode = 0;
    @(negedge clk);
    chk("rst_post_in_ready", 32'(bus.in_ready), 1);
    @(posedge clk); #1;
    push_exp(16'd1, 1'b0, 1'b0);
    push_exp(16'd6, 1'b0, 1'b0);
    push_exp(16'd11, 1'b0, 1'b1);
    send_word(16'hAC70, 1'b1);
    wait_done("after_reset");

    // Random streams with stalls on both sides. The final word of each
    // stream starts with a 1, so a complete codeword is always buffered when
    // the stream end becomes known.
    in_stall_en = 1'b1;
    rdy_mode = 1;
    for (int s = 0; s < 25; s++) begin
      k = 4'($urandom_range(0, 15));
      nw = $urandom_range(1, 6);
      wq.delete();
      for (int i = 0; i < nw; i++) begin
        sel = $urandom_range(0, 3);
        if (sel == 0)      wq.push_back(16'h0000);
        else if (sel == 1) wq.push_back(16'($urandom & $urandom & $urandom));
        else               wq.push_back(16'($urandom));
      end
      wq[nw - 1] = wq[nw - 1] | 16'h8000;
      model(wq, 32'(k));
      send_stream(wq);
      wait_done("random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
